// File: rtl/shift_unloader.sv
// shift_unloader: parallel-in / serial-out frame unloader.
// Captures a flattened frame of SIZE words and emits it one word per
// accepted beat over a valid/ready handshake. Default order is word SIZE-1
// first, word 0 last (replays the arrival order of a shifted-in window).
// Build option: define SHIFT_UNLOADER_LSB_FIRST_EN to emit word 0 first and
// word SIZE-1 last instead; handshake and timing are unchanged.
module shift_unloader #(
    parameter int SIZE       = 5,
    parameter int DATA_WIDTH = 16
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic [SIZE*DATA_WIDTH-1:0] data_in,
    input  logic                       in_valid,
    output logic                       in_ready,
    output logic [DATA_WIDTH-1:0]      out_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic                       out_last
);

    localparam int FRAME_WIDTH = SIZE * DATA_WIDTH;
    localparam int CNT_WIDTH   = $clog2(SIZE + 1);

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_SHIFT = 1'b1;

    localparam logic [CNT_WIDTH-1:0] CNT_FULL = CNT_WIDTH'(SIZE);
    localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);
    localparam logic [CNT_WIDTH-1:0] CNT_TWO  = CNT_WIDTH'(2);
    localparam logic [CNT_WIDTH-1:0] CNT_ZERO = CNT_WIDTH'(0);

`ifdef SHIFT_UNLOADER_LSB_FIRST_EN
    // Word that leaves first: the least significant word of the buffer.
    function automatic logic [DATA_WIDTH-1:0] head_word(input logic [FRAME_WIDTH-1:0] f);
        return f[DATA_WIDTH-1:0];
    endfunction

    // Drop the emitted word so the next one moves to the head position.
    function automatic logic [FRAME_WIDTH-1:0] advance_frame(input logic [FRAME_WIDTH-1:0] f);
        return f >> DATA_WIDTH;
    endfunction
`else
    // Word that leaves first: the most significant word of the buffer.
    function automatic logic [DATA_WIDTH-1:0] head_word(input logic [FRAME_WIDTH-1:0] f);
        return f[FRAME_WIDTH-1 -: DATA_WIDTH];
    endfunction

    // Drop the emitted word so the next one moves to the head position.
    function automatic logic [FRAME_WIDTH-1:0] advance_frame(input logic [FRAME_WIDTH-1:0] f);
        return f << DATA_WIDTH;
    endfunction
`endif

    logic [0:0]            state_r,     state_s;
    logic [FRAME_WIDTH-1:0] frame_r,    frame_s;
    logic [CNT_WIDTH-1:0]  remaining_r, remaining_s;
    logic [DATA_WIDTH-1:0] out_data_r,  out_data_s;
    logic                  out_valid_r, out_valid_s;
    logic                  out_last_r,  out_last_s;
    logic                  in_ready_s;
    logic                  load_s;
    logic                  beat_s;

    // Upstream may load when idle, or on the final beat so frames abut.
    always_comb begin
        in_ready_s = 1'b0;
        case (state_r)
            ST_IDLE:  in_ready_s = 1'b1;
            ST_SHIFT: in_ready_s = out_last_r & out_ready;
            default:  in_ready_s = 1'b0;
        endcase
    end

    // Next-state logic: load a new frame, advance on a beat, or hold.
    always_comb begin
        state_s     = state_r;
        frame_s     = frame_r;
        remaining_s = remaining_r;
        out_data_s  = out_data_r;
        out_valid_s = out_valid_r;
        out_last_s  = out_last_r;
        load_s      = in_valid & in_ready_s;
        beat_s      = out_valid_r & out_ready;

        if (load_s) begin
            // First word is presented straight away; the buffer keeps the rest.
            state_s     = ST_SHIFT;
            frame_s     = advance_frame(data_in);
            remaining_s = CNT_FULL;
            out_data_s  = head_word(data_in);
            out_valid_s = 1'b1;
            out_last_s  = (CNT_FULL == CNT_ONE);
        end else if (beat_s && out_last_r) begin
            // Final word accepted with nothing queued behind it.
            state_s     = ST_IDLE;
            remaining_s = CNT_ZERO;
            out_valid_s = 1'b0;
            out_last_s  = 1'b0;
        end else if (beat_s) begin
            frame_s     = advance_frame(frame_r);
            remaining_s = remaining_r - CNT_ONE;
            out_data_s  = head_word(frame_r);
            out_valid_s = 1'b1;
            out_last_s  = (remaining_r == CNT_TWO);
        end else begin
            // No beat: everything held, which keeps out_data stable under backpressure.
            state_s     = state_r;
            frame_s     = frame_r;
            remaining_s = remaining_r;
        end
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state_r     <= ST_IDLE;
            frame_r     <= '0;
            remaining_r <= CNT_ZERO;
            out_data_r  <= '0;
            out_valid_r <= 1'b0;
            out_last_r  <= 1'b0;
        end else begin
            state_r     <= state_s;
            frame_r     <= frame_s;
            remaining_r <= remaining_s;
            out_data_r  <= out_data_s;
            out_valid_r <= out_valid_s;
            out_last_r  <= out_last_s;
        end
    end

    assign in_ready  = in_ready_s;
    assign out_data  = out_data_r;
    assign out_valid = out_valid_r;
    assign out_last  = out_last_r;

endmodule

// File: tb/tb_shift_unloader.sv
// Directed self-checking bench for shift_unloader (SIZE=5, DATA_WIDTH=16).
// Word order expectations follow SHIFT_UNLOADER_LSB_FIRST_EN when defined.
module tb_shift_unloader;

    localparam int SIZE = 5;
    localparam int DW   = 16;

    logic              clock;
    logic              reset;
    logic [SIZE*DW-1:0] data_in;
    logic              in_valid;
    logic              in_ready;
    logic [DW-1:0]     out_data;
    logic              out_valid;
    logic              out_ready;
    logic              out_last;

    int n_checks;
    int n_fails;

    logic [SIZE*DW-1:0] frame1;
    logic [SIZE*DW-1:0] frame2;
    logic [SIZE*DW-1:0] junk;

    shift_unloader #(.SIZE(SIZE), .DATA_WIDTH(DW)) dut (
        .clock     (clock),
        .reset     (reset),
        .data_in   (data_in),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_last  (out_last)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        n_checks++;
        if (observed !== expected) begin
            n_fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Expected word for beat i of a frame, in emission order.
    function automatic logic [DW-1:0] exp_word(input logic [SIZE*DW-1:0] f, input int i);
        int idx;
`ifdef SHIFT_UNLOADER_LSB_FIRST_EN
        idx = i;
`else
        idx = SIZE - 1 - i;
`endif
        return f[idx*DW +: DW];
    endfunction

    // Checks the outputs while beat i of frame f is being presented.
    task automatic expect_beat(input string tag, input logic [SIZE*DW-1:0] f, input int i);
        check($sformatf("%s_valid%0d", tag, i), {31'd0, out_valid}, 32'd1);
        check($sformatf("%s_data%0d", tag, i), {16'd0, out_data}, {16'd0, exp_word(f, i)});
        check($sformatf("%s_last%0d", tag, i), {31'd0, out_last}, (i == SIZE - 1) ? 32'd1 : 32'd0);
        check($sformatf("%s_rdy%0d", tag, i), {31'd0, in_ready},
              ((i == SIZE - 1) && out_ready) ? 32'd1 : 32'd0);
    endtask

    task automatic expect_idle(input string tag);
        check({tag, "_valid"}, {31'd0, out_valid}, 32'd0);
        check({tag, "_rdy"}, {31'd0, in_ready}, 32'd1);
    endtask

    // Presents frame f for one edge (in_ready must already be high).
    task automatic load(input string tag, input logic [SIZE*DW-1:0] f);
        check({tag, "_load_rdy"}, {31'd0, in_ready}, 32'd1);
        data_in  = f;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        data_in  = '0;
    endtask

    initial begin
        n_checks  = 0;
        n_fails   = 0;
        frame1    = {16'h0005, 16'h0004, 16'h0003, 16'h0002, 16'h0001};
        frame2    = {16'h00A4, 16'h00A3, 16'h00A2, 16'h00A1, 16'h00A0};
        junk      = {16'hDEAD, 16'hBEEF, 16'hCAFE, 16'hF00D, 16'h1234};
        reset     = 1'b0;
        data_in   = '0;
        in_valid  = 1'b0;
        out_ready = 1'b0;

        // Test 1: reset held two cycles
        tick();
        tick();
        check("rst_valid", {31'd0, out_valid}, 32'd0);
        check("rst_data", {16'd0, out_data}, 32'h0000);
        check("rst_last", {31'd0, out_last}, 32'd0);
        check("rst_rdy", {31'd0, in_ready}, 32'd1);
        reset = 1'b1;
        tick();
        expect_idle("post_rst");

        // Test 2: plain drain with out_ready high
        out_ready = 1'b1;
        load("t2", frame1);
        for (int i = 0; i < SIZE; i++) begin
            expect_beat("t2", frame1, i);
            tick();
        end
        expect_idle("t2_end");

        // Test 3: backpressure on the second word; in_valid while busy ignored
        load("t3", frame1);
        expect_beat("t3", frame1, 0);
        tick();
        expect_beat("t3", frame1, 1);
        out_ready = 1'b0;
        in_valid  = 1'b1;
        data_in   = junk;
        for (int c = 0; c < 3; c++) begin
            tick();
            check($sformatf("t3_hold_data%0d", c), {16'd0, out_data}, {16'd0, exp_word(frame1, 1)});
            check($sformatf("t3_hold_valid%0d", c), {31'd0, out_valid}, 32'd1);
            check($sformatf("t3_hold_last%0d", c), {31'd0, out_last}, 32'd0);
            check($sformatf("t3_hold_rdy%0d", c), {31'd0, in_ready}, 32'd0);
        end
        in_valid  = 1'b0;
        data_in   = '0;
        out_ready = 1'b1;
        for (int i = 1; i < SIZE; i++) begin
            expect_beat("t3", frame1, i);
            tick();
        end
        expect_idle("t3_end");

        // Test 4: back-to-back frames with no bubble
        load("t4a", frame1);
        for (int i = 0; i < SIZE; i++) begin
            expect_beat("t4a", frame1, i);
            if (i == SIZE - 1) begin
                data_in  = frame2;
                in_valid = 1'b1;
            end
            tick();
        end
        in_valid = 1'b0;
        data_in  = '0;
        for (int i = 0; i < SIZE; i++) begin
            expect_beat("t4b", frame2, i);
            tick();
        end
        expect_idle("t4_end");

        // Test 5: reset after two words discards the rest of the frame
        load("t5", frame1);
        expect_beat("t5", frame1, 0);
        tick();
        expect_beat("t5", frame1, 1);
        tick();
        reset = 1'b0;
        tick();
        reset = 1'b1;
        expect_idle("t5_rst");
        check("t5_rst_data", {16'd0, out_data}, 32'h0000);
        check("t5_rst_last", {31'd0, out_last}, 32'd0);
        for (int c = 0; c < SIZE; c++) begin
            tick();
            check($sformatf("t5_quiet%0d", c), {31'd0, out_valid}, 32'd0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
